timer_display: RTL and testbench
================================

Name: timer_display

Overview:
- Downstream consumer of the countdown timer's 16-bit count and its terminal flag `T`.
- Converts the binary count to BCD with a sequential shift-add-3 (double-dabble) engine.
- Drives a 4-digit, time-multiplexed, common-anode 7-segment display, with optional leading-zero blanking.
- Shows timer expiry on the decimal point. Sits between the timer and the board display pins.

Parameters:
- SCAN_DIV, 16'd50000, clk cycles each digit stays active; must be ≥ 2.
- SCAN_W, 16, width of the scan divider counter.
- BLANK_LZ, 1'b1, when 1 leading zeros on digits 3..1 are blanked.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- count_in  input  16  binary count from the timer.
- T  input  1  timer terminal flag; 1 = count reached zero.
- an  output  4  digit anodes, active-low; bit i selects digit i (digit 0 = least significant).
- seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  output  1  decimal point, active-low.
- busy  output  1  1 while a conversion is in progress.
- ovf  output  1  1 when the last converted value exceeded 9999.

Behaviour:
- Reset values (asynchronous): `an`=4'b1111, `seg`=7'b1111111, `dp`=1, `busy`=0, `ovf`=0, displayed BCD=0, scan index=0, scan counter=0, FSM=IDLE, snapshot valid=0.
- FSM states: IDLE, CONV, DONE.
- IDLE → CONV when snapshot valid=0 or `count_in` ≠ snapshot. On that edge:
  - load snapshot ← `count_in` and binary shift register ← `count_in`;
  - clear the 20-bit BCD register (5 nibbles);
  - iteration counter ← 0; `busy` ← 1.
- CONV, once per cycle:
  - add 3 to each BCD nibble that is ≥ 5;
  - then shift {BCD, binary} left by 1;
  - increment the iteration counter.
  - After the 16th shift go to DONE.
- DONE, one cycle:
  - if nibble 4 ≠ 0 or the value > 9999, displayed BCD ← 9,9,9,9 and `ovf` ← 1;
  - otherwise displayed BCD ← low 4 nibbles and `ovf` ← 0;
  - set snapshot valid ← 1, `busy` ← 0, go to IDLE.
- Latency: the displayed BCD updates exactly 18 clk edges after the edge on which the change is sampled (1 load + 16 CONV + 1 DONE).
- `count_in` changes during CONV/DONE are ignored. They are caught on return to IDLE by the snapshot compare. The final displayed value always equals the last stable `count_in`, subject to saturation.
- Displayed BCD holds its old value throughout a conversion. No partial results are ever shown.
- Scan divider:
  - counts 0..SCAN_DIV-1;
  - at terminal count it wraps to 0 and the scan index advances mod 4 (3 → 0).
- Outputs are registered from the current scan index and displayed BCD: `an` = one-hot-low of the index.
- `seg` comes from the 7-seg decode of the selected nibble. Digit 0 is never blanked.
- Blanking: with BLANK_LZ=1, digit i ∈ {1,2,3} has `seg`=7'b1111111 when it and all higher displayed digits are 0.
- Decimal point: `dp`=0 on digit 0 when `T`=1, and on digit 3 when `ovf`=1. Otherwise `dp`=1. `T` is sampled with the same registered timing as `seg`.
- Encodings 0–9 follow the standard active-low segment table. Nibbles > 9 cannot occur. If one does, the decoder outputs all-off.
- Reset mid-conversion: abort immediately to the reset values. The next conversion starts on the first edge after `rst` deasserts.

Decomposition:
- Shared package (timer_pkg):
  - FSM state encodings IDLE/CONV/DONE;
  - constant BCD_MAX = 16'd9999;
  - constants SEG_BLANK = 7'b1111111 and AN_OFF = 4'b1111;
  - the 7-seg encoding constants for 0–9.
- Sub-module seg7_decode: 4-bit nibble → 7-bit active-low segments, purely combinational. The register stage lives in timer_display.

Test Plan:
- Reset, `count_in`=0, `T`=1:
  - during `rst`, `an`=4'b1111;
  - within 18 cycles of release, BCD = 0 and `busy` falls;
  - digit 0 shows `seg`=7'b1000000 with `dp`=0;
  - digits 1–3 are blanked.
- `count_in`=16'd30, `T`=0: after 18 cycles the BCD is 0,0,3,0. Over four scan slots, digit 1 shows 7'b0110000, digit 0 shows 7'b1000000, and digits 2–3 are blanked.
- `count_in` changes 30 → 29 at cycle 5 of a conversion: the first result shows 30. A second conversion starts on return to IDLE and shows 29. `busy` is high for both windows.
- `count_in`=16'd12345: display shows 9999, `ovf`=1, `dp`=0 on digit 3 only. Then `count_in`=16'd9999 gives 9999 with `ovf`=0.
- SCAN_DIV=4: `an` sequence is 1110, 1101, 1011, 0111, 1110, each held exactly 4 cycles.
- Assert `rst` during CONV: all outputs return to their reset values the same cycle. After release, the current `count_in` is reconverted.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and constants for the timer display path: FSM states,
// saturation limit, display constants and the active-low segment table.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [15:0] BCD_MAX   = 16'd9999;
  localparam logic [6:0]  SEG_BLANK = 7'b1111111;
  localparam logic [3:0]  AN_OFF    = 4'b1111;

  // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;

  // Double-dabble correction: bias every nibble that is 5 or more by 3
  // so the following left shift carries correctly into the next digit.
  function automatic logic [19:0] add3(input logic [19:0] bcd);
    logic [19:0] r;
    r = bcd;
    for (int i = 0; i < 5; i++) begin
      if (bcd[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = bcd[i*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD nibble to active-low 7-segment decoder.
module seg7_decode
  import timer_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    // NOTE: a default on every path of a combinational block prevents an inferred latch.
    seg = SEG_BLANK;
    case (nibble)
      4'd0: seg = SEG_0;
      4'd1: seg = SEG_1;
      4'd2: seg = SEG_2;
      4'd3: seg = SEG_3;
      4'd4: seg = SEG_4;
      4'd5: seg = SEG_5;
      4'd6: seg = SEG_6;
      4'd7: seg = SEG_7;
      4'd8: seg = SEG_8;
      4'd9: seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/timer_display.sv
// Binary-to-BCD conversion of the timer count and multiplexed drive of a
// 4-digit common-anode display with leading-zero blanking and expiry dp.
module timer_display
  import timer_pkg::*;
#(
  parameter int unsigned       SCAN_W   = 16,
  parameter logic [SCAN_W-1:0] SCAN_DIV = 16'd50000,
  parameter logic              BLANK_LZ = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] count_in,
  input  logic        T,
  output logic [3:0]  an,
  output logic [6:0]  seg,
  output logic        dp,
  output logic        busy,
  output logic        ovf
);

  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_DIV - 1'b1;

  state_t      state_q, state_d;
  logic        start, step, finish;
  logic [15:0] snapshot;
  logic        snap_valid;
  logic [15:0] bin;
  logic [19:0] bcd;
  logic [3:0]  iter;
  logic [15:0] disp;

  logic [SCAN_W-1:0] scan_cnt;
  logic [1:0]        scan_idx;

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    step    = 1'b0;
    finish  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!snap_valid || (count_in != snapshot)) begin
          start   = 1'b1;
          state_d = CONV;
        end
      end
      CONV: begin
        step = 1'b1;
        if (iter == 4'd15) state_d = DONE;
      end
      DONE: begin
        finish  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Conversion datapath; disp only changes on the DONE cycle, so the
  // display never sees a partially converted value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: sequential state is written with <= so every register samples pre-edge values.
      snapshot   <= '0;
      snap_valid <= 1'b0;
      bin        <= '0;
      bcd        <= '0;
      iter       <= '0;
      disp       <= '0;
      busy       <= 1'b0;
      ovf        <= 1'b0;
    end else begin
      if (start) begin
        snapshot <= count_in;
        bin      <= count_in;
        bcd      <= '0;
        iter     <= '0;
        busy     <= 1'b1;
      end
      if (step) begin
        {bcd, bin} <= {add3(bcd), bin} << 1;
        iter       <= iter + 4'd1;
      end
      if (finish) begin
        if ((bcd[19:16] != 4'd0) || (snapshot > BCD_MAX)) begin
          disp <= 16'h9999;
          ovf  <= 1'b1;
        end else begin
          disp <= bcd[15:0];
          ovf  <= 1'b0;
        end
        snap_valid <= 1'b1;
        busy       <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt <= '0;
      scan_idx <= '0;
    end else if (scan_cnt == SCAN_LAST) begin
      scan_cnt <= '0;
      scan_idx <= scan_idx + 2'd1;
    end else begin
      scan_cnt <= scan_cnt + 1'b1;
    end
  end

  logic [3:0] nibble;
  logic [6:0] seg_raw;
  logic [3:0] lead_zero;
  logic       blank;
  logic [3:0] an_d;
  logic [6:0] seg_d;
  logic       dp_d;

  seg7_decode u_decode (
    .nibble (nibble),
    .seg    (seg_raw)
  );

  // lead_zero[i]: digit i and every higher digit are zero.
  always_comb begin
    nibble       = disp[scan_idx*4 +: 4];
    lead_zero[3] = (disp[15:12] == 4'd0);
    lead_zero[2] = lead_zero[3] && (disp[11:8] == 4'd0);
    lead_zero[1] = lead_zero[2] && (disp[7:4] == 4'd0);
    lead_zero[0] = 1'b0;
    blank        = BLANK_LZ && lead_zero[scan_idx];
    an_d         = ~(4'b0001 << scan_idx);
    seg_d        = blank ? SEG_BLANK : seg_raw;
    dp_d         = !(((scan_idx == 2'd0) && T) || ((scan_idx == 2'd3) && ovf));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= AN_OFF;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= an_d;
      seg <= seg_d;
      dp  <= dp_d;
    end
  end

endmodule

// File: tb/tb_timer_display.sv
// Directed bench for timer_display with a short scan period so every
// digit slot can be observed within a few cycles.
module tb_timer_display;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] count_in;
  logic        T;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        busy;
  logic        ovf;

  int vectors     = 0;
  int miscompares = 0;

  logic [6:0] cap_seg  [4];
  logic       cap_dp   [4];
  bit         cap_seen [4];

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S3 = 7'b0110000;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] S9 = 7'b0010000;
  localparam logic [6:0] SB = 7'b1111111;

  timer_display #(
    .SCAN_W   (16),
    .SCAN_DIV (16'd4),
    .BLANK_LZ (1'b1)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .count_in (count_in),
    .T        (T),
    .an       (an),
    .seg      (seg),
    .dp       (dp),
    .busy     (busy),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  // Counts negedge samples with busy high, starting on the next negedge.
  task automatic measure_busy(output int n);
    n = 0;
    @(negedge clk);
    while (busy === 1'b1 && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_busy_low(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: busy still %b after %0d cycles, required 0", tag, busy, n);
    end
  endtask

  // Records the last seg/dp seen in each digit slot.
  task automatic capture(input int cycles);
    for (int d = 0; d < 4; d++) cap_seen[d] = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        if (an === ~(4'b0001 << d)) begin
          cap_seg[d]  = seg;
          cap_dp[d]   = dp;
          cap_seen[d] = 1'b1;
        end
      end
    end
  endtask

  task automatic test_reset;
    int n;
    logic [6:0] es [4];
    rst = 1'b1; count_in = 16'd0; T = 1'b1;
    repeat (2) @(negedge clk);
    vectors++;
    if (an !== 4'b1111 || seg !== SB || dp !== 1'b1 || busy !== 1'b0 || ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_hold: an=%b seg=%b dp=%b busy=%b ovf=%b, required 1111 1111111 1 0 0",
               an, seg, dp, busy, ovf);
    end
    rst = 1'b0;
    measure_busy(n);
    vectors++;
    if (n !== 17) begin
      miscompares++;
      $display("FAIL reset_latency: busy high %0d cycles, required 17", n);
    end
    @(negedge clk);
    capture(16);
    es = '{S0, SB, SB, SB};
    for (int d = 0; d < 4; d++) begin
      vectors++;
      if (!cap_seen[d] || cap_seg[d] !== es[d] || cap_dp[d] !== (d != 0)) begin
        miscompares++;
        $display("FAIL reset_digit%0d: seen=%b seg=%b dp=%b, required seg=%b dp=%b",
                 d, cap_seen[d], cap_seg[d], cap_dp[d], es[d], (d != 0));
      end
    end
  endtask

  task automatic test_change_mid;
    logic [6:0] es [4];
    T = 1'b0;
    count_in = 16'd30;
    @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_busy1: busy=%b, required 1", busy);
    end
    repeat (4) @(negedge clk);
    count_in = 16'd29;
    wait_busy_low("mid_first_done");
    @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_busy2: busy=%b, required 1 (reconversion)", busy);
    end
    capture(16);
    es = '{S0, S3, SB, SB};
    for (int d = 0; d < 4; d++) begin
      vectors++;
      if (!cap_seen[d] || cap_seg[d] !== es[d]) begin
        miscompares++;
        $display("FAIL mid_first_digit%0d: seen=%b seg=%b, required %b", d, cap_seen[d], cap_seg[d], es[d]);
      end
    end
    wait_busy_low("mid_second_done");
    @(negedge clk);
    capture(16);
    es = '{S9, S2, SB, SB};
    for (int d = 0; d < 4; d++) begin
      vectors++;
      if (!cap_seen[d] || cap_seg[d] !== es[d] || cap_dp[d] !== 1'b1) begin
        miscompares++;
        $display("FAIL mid_second_digit%0d: seen=%b seg=%b dp=%b, required %b 1",
                 d, cap_seen[d], cap_seg[d], cap_dp[d], es[d]);
      end
    end
  endtask

  task automatic test_thirty;
    int n;
    logic [6:0] es [4];
    count_in = 16'd30;
    measure_busy(n);
    vectors++;
    if (n !== 17) begin
      miscompares++;
      $display("FAIL thirty_latency: busy high %0d cycles, required 17", n);
    end
    @(negedge clk);
    capture(16);
    es = '{S0, S3, SB, SB};
    for (int d = 0; d < 4; d++) begin
      vectors++;
      if (!cap_seen[d] || cap_seg[d] !== es[d] || cap_dp[d] !== 1'b1) begin
        miscompares++;
        $display("FAIL thirty_digit%0d: seen=%b seg=%b dp=%b, required %b 1",
                 d, cap_seen[d], cap_seg[d], cap_dp[d], es[d]);
      end
    end
  endtask

  task automatic test_overflow;
    count_in = 16'd12345;
    @(negedge clk);
    wait_busy_low("ovf_done");
    @(negedge clk);
    capture(16);
    vectors++;
    if (ovf !== 1'b1) begin
      miscompares++;
      $display("FAIL ovf_flag: ovf=%b, required 1", ovf);
    end
    for (int d = 0; d < 4; d++) begin
      vectors++;
      if (!cap_seen[d] || cap_seg[d] !== S9 || cap_dp[d] !== (d != 3)) begin
        miscompares++;
        $display("FAIL ovf_digit%0d: seen=%b seg=%b dp=%b, required %b %b",
                 d, cap_seen[d], cap_seg[d], cap_dp[d], S9, (d != 3));
      end
    end
  endtask

  task automatic test_reset_mid;
    int n;
    logic [6:0] es [4];
    count_in = 16'd77;
    repeat (5) @(negedge clk);
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL rmid_busy: busy=%b, required 1", busy);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if (an !== 4'b1111 || seg !== SB || dp !== 1'b1 || busy !== 1'b0 || ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL rmid_abort: an=%b seg=%b dp=%b busy=%b ovf=%b, required 1111 1111111 1 0 0",
               an, seg, dp, busy, ovf);
    end
    @(negedge clk);
    rst = 1'b0;
    measure_busy(n);
    vectors++;
    if (n !== 17) begin
      miscompares++;
      $display("FAIL rmid_latency: busy high %0d cycles, required 17", n);
    end
    @(negedge clk);
    capture(16);
    es = '{S7, S7, SB, SB};
    for (int d = 0; d < 4; d++) begin
      vectors++;
      if (!cap_seen[d] || cap_seg[d] !== es[d] || cap_dp[d] !== 1'b1) begin
        miscompares++;
        $display("FAIL rmid_digit%0d: seen=%b seg=%b dp=%b, required %b 1",
                 d, cap_seen[d], cap_seg[d], cap_dp[d], es[d]);
      end
    end
  endtask

  task automatic test_max;
    count_in = 16'd9999;
    @(negedge clk);
    wait_busy_low("max_done");
    @(negedge clk);
    capture(16);
    vectors++;
    if (ovf !== 1'b0) begin
      miscompares++;
      $display("FAIL max_ovf: ovf=%b, required 0", ovf);
    end
    for (int d = 0; d < 4; d++) begin
      vectors++;
      if (!cap_seen[d] || cap_seg[d] !== S9 || cap_dp[d] !== 1'b1) begin
        miscompares++;
        $display("FAIL max_digit%0d: seen=%b seg=%b dp=%b, required %b 1",
                 d, cap_seen[d], cap_seg[d], cap_dp[d], S9);
      end
    end
  endtask

  task automatic test_scan;
    logic [3:0] pats [5];
    logic [3:0] prev;
    int n = 0;
    pats = '{4'b1110, 4'b1101, 4'b1011, 4'b0111, 4'b1110};
    prev = an;
    @(negedge clk);
    while (!(an === 4'b1110 && prev === 4'b0111) && n < 100) begin
      prev = an;
      @(negedge clk);
      n++;
    end
    vectors++;
    if (n >= 100) begin
      miscompares++;
      $display("FAIL scan_sync: no 0111->1110 transition, an=%b", an);
    end
    for (int p = 0; p < 5; p++) begin
      for (int k = 0; k < 4; k++) begin
        vectors++;
        if (an !== pats[p]) begin
          miscompares++;
          $display("FAIL scan_slot%0d_cycle%0d: an=%b, required %b", p, k, an, pats[p]);
        end
        @(negedge clk);
      end
    end
  endtask

  initial begin
    test_reset;
    test_change_mid;
    test_thirty;
    test_overflow;
    test_reset_mid;
    test_max;
    test_scan;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
